// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for a 16-bit accumulator-less CPU.
// Drives register file, ALU and data memory controls from a latched instruction.
module cpu_sequencer #(
    parameter logic [5:0] RESET_PC   = 6'd0,
    parameter bit         FETCH_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [5:0]  pc_out,
    input  logic [15:0] imem_data,
    output logic [2:0]  rf_raddr_a,
    output logic [2:0]  rf_raddr_b,
    output logic [2:0]  rf_waddr,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic [1:0]  alu_op,
    input  logic        alu_zero,
    output logic [5:0]  dmem_addr,
    output logic        dmem_re,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        z_q, z_d;

    logic [3:0]  opcode;
    logic [5:0]  imm;
    logic        is_alu;
    logic        is_ill;
    logic        take_jump;
    logic        fetch_go;

    assign opcode     = ir_q[15:12];
    assign imm        = ir_q[5:0];
    assign is_alu     = opcode inside {[4'h1:4'h4]};
    assign is_ill     = opcode inside {[4'hA:4'hE]};
    assign take_jump  = (opcode == OP_JMP) || ((opcode == OP_BEQZ) && z_q);
    // With FETCH_HOLD cleared the sequencer free-runs and ignores run.
    assign fetch_go   = run | ~FETCH_HOLD;

    assign pc_out     = pc_q;
    assign rf_raddr_a = ir_q[8:6];
    assign rf_raddr_b = ir_q[11:9];
    assign rf_waddr   = ir_q[11:9];
    assign dmem_addr  = ir_q[5:0];

    // State, PC, instruction and zero-flag registers; reset clears them at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
        end
    end

    // Next-state, strobes, and the PC update taken on every return to FETCH.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        rf_we   = 1'b0;
        rf_wsel = 2'd0;
        alu_op  = 2'd0;
        dmem_re = 1'b0;
        dmem_we = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (fetch_go) begin
                    ir_d    = imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                illegal = is_ill;
                state_d = (opcode == OP_HLT) ? HALT : EXEC;
            end
            EXEC: begin
                if (is_alu) begin
                    alu_op = 2'(opcode - 4'd1);
                    z_d    = alu_zero;
                end
                if (is_alu || (opcode == OP_LDI)) begin
                    state_d = WB;
                end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
                    state_d = MEM;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM: begin
                dmem_re = (opcode == OP_LD);
                dmem_we = (opcode == OP_ST);
                if (dmem_ready) begin
                    state_d = (opcode == OP_LD) ? WB : FETCH;
                end
            end
            WB: begin
                rf_we   = 1'b1;
                if (opcode == OP_LD) begin
                    rf_wsel = 2'd2;
                end else if (opcode == OP_LDI) begin
                    rf_wsel = 2'd1;
                end
                state_d = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if ((state_q != FETCH) && (state_d == FETCH)) begin
            pc_d = take_jump ? imm : pc_q + 6'd1;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed programs with a scoreboard of expected control events.
// A negedge monitor pops and compares each observed event against the queue.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [5:0]  pc_out;
    logic [15:0] imem_data;
    logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        rf_we;
    logic [1:0]  rf_wsel, alu_op;
    logic        alu_zero;
    logic [5:0]  dmem_addr;
    logic        dmem_re, dmem_we, dmem_ready;
    logic        halted, illegal;

    cpu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .pc_out     (pc_out),
        .imem_data  (imem_data),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .alu_op     (alu_op),
        .alu_zero   (alu_zero),
        .dmem_addr  (dmem_addr),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Datapath model: memories, register file, ALU and a wait-state memory.
    logic [15:0] imem [64];
    logic [15:0] dmem [64];
    logic [15:0] regs [8];
    logic [15:0] alu_now, alu_q, opa, opb;
    int          wcnt;
    int          mem_wait;

    assign imem_data  = imem[pc_out];
    assign alu_zero   = (alu_now == 16'd0);
    assign dmem_ready = (dmem_re | dmem_we) && (wcnt >= mem_wait);

    always_comb begin
        opa = regs[rf_raddr_a];
        opb = regs[rf_raddr_b];
        case (alu_op)
            2'd0:    alu_now = opb + opa;
            2'd1:    alu_now = opb - opa;
            2'd2:    alu_now = opb & opa;
            default: alu_now = opb | opa;
        endcase
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            alu_q <= '0;
            wcnt  <= 0;
        end else begin
            if (rf_we) begin
                case (rf_wsel)
                    2'd0:    regs[rf_waddr] <= alu_q;
                    2'd1:    regs[rf_waddr] <= {10'd0, dmem_addr};
                    default: regs[rf_waddr] <= dmem[dmem_addr];
                endcase
            end else begin
                alu_q <= alu_now;
            end
            wcnt <= (dmem_re | dmem_we) ? wcnt + 1 : 0;
        end
    end

    // Scoreboard
    localparam logic [2:0] K_WE  = 3'd0;
    localparam logic [2:0] K_DRE = 3'd1;
    localparam logic [2:0] K_DWE = 3'd2;
    localparam logic [2:0] K_ILL = 3'd3;
    localparam logic [2:0] K_ALU = 3'd4;
    localparam logic [2:0] K_HLT = 3'd5;
    localparam logic [2:0] K_PC  = 3'd6;

    typedef struct packed {
        logic [2:0]  kind;
        logic [5:0]  val;
        logic [1:0]  aux;
        logic [15:0] rel;
    } ev_t;

    ev_t        expq[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         base = 0;
    bit         mon_en = 1'b0;
    logic [5:0] prev_pc;
    logic       prev_halted;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [2:0] k, input logic [5:0] v,
                             input logic [1:0] a, input int rel);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.aux  = a;
        e.rel  = 16'(rel);
        expq.push_back(e);
    endtask

    task automatic observe(input logic [2:0] k, input logic [5:0] v,
                           input logic [1:0] a);
        ev_t got, want;
        got.kind = k;
        got.val  = v;
        got.aux  = a;
        got.rel  = 16'(cyc - base + 1);
        tests++;
        if (expq.size() == 0) begin
            fails++;
            $display("FAIL event: got kind=%0d val=%0d aux=%0d cycle=%0d, expected none",
                     got.kind, got.val, got.aux, got.rel);
        end else begin
            want = expq.pop_front();
            if (got !== want) begin
                fails++;
                $display("FAIL event: got kind=%0d val=%0d aux=%0d cycle=%0d, expected kind=%0d val=%0d aux=%0d cycle=%0d",
                         got.kind, got.val, got.aux, got.rel,
                         want.kind, want.val, want.aux, want.rel);
            end
        end
    endtask

    // Monitor: turns DUT activity into events and checks strobe invariants.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rf_we)              observe(K_WE, {3'd0, rf_waddr}, rf_wsel);
            if (dmem_re)            observe(K_DRE, dmem_addr, 2'd0);
            if (dmem_we)            observe(K_DWE, dmem_addr, 2'd0);
            if (illegal)            observe(K_ILL, 6'd0, 2'd0);
            if (alu_op != 2'd0)     observe(K_ALU, {4'd0, alu_op}, 2'd0);
            if (halted && !prev_halted) observe(K_HLT, 6'd0, 2'd0);
            if (pc_out != prev_pc)  observe(K_PC, pc_out, 2'd0);
            check("strobe_excl", 32'($countones({rf_we, dmem_re, dmem_we}) <= 1), 32'd1);
            if (halted) check("halt_quiet", {29'd0, rf_we, dmem_re, dmem_we}, 32'd0);
        end
        prev_pc     <= pc_out;
        prev_halted <= halted;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset  = 1'b0;
        run    = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        mon_en = 1'b1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    endtask

    task automatic start();
        base = cyc;
        run  = 1'b1;
    endtask

    task automatic drained(input string name);
        check(name, 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    initial begin
        reset    = 1'b0;
        run      = 1'b0;
        mem_wait = 0;
        clear_imem();
        for (int i = 0; i < 64; i++) dmem[i] = 16'hA000 + 16'(i);
        #1;
        check("reset_state",
              {11'd0, pc_out, halted, illegal, rf_we, dmem_re, dmem_we,
               alu_op, rf_wsel, rf_raddr_a, rf_raddr_b}, 32'd0);

        // Idle with run low: no fetch, PC stays at reset value.
        do_reset();
        base = cyc;
        idle(6);
        check("idle_pc", {26'd0, pc_out}, 32'd0);
        drained("idle_drain");

        // LDI r1,5; LDI r2,5; SUB r1,r2; BEQZ 10
        clear_imem();
        imem[0] = 16'h5205;
        imem[1] = 16'h5405;
        imem[2] = 16'h2280;
        imem[3] = 16'h900A;
        do_reset();
        expect_ev(K_WE, 6'd1, 2'd1, 4);
        expect_ev(K_PC, 6'd1, 2'd0, 5);
        expect_ev(K_WE, 6'd2, 2'd1, 8);
        expect_ev(K_PC, 6'd2, 2'd0, 9);
        expect_ev(K_ALU, 6'd1, 2'd0, 11);
        expect_ev(K_WE, 6'd1, 2'd0, 12);
        expect_ev(K_PC, 6'd3, 2'd0, 13);
        expect_ev(K_PC, 6'd10, 2'd0, 16);
        start();
        idle(15);
        run = 1'b0;
        idle(6);
        check("beqz_taken_pc", {26'd0, pc_out}, 32'd10);
        check("sub_result", {16'd0, regs[1]}, 32'd0);
        drained("beqz_drain");

        // Non-zero SUB then LDI with a zero ALU flag: BEQZ must fall through.
        clear_imem();
        imem[0] = 16'h5207;
        imem[1] = 16'h5403;
        imem[2] = 16'h2280;
        imem[3] = 16'h5800;
        imem[4] = 16'h900A;
        do_reset();
        expect_ev(K_WE, 6'd1, 2'd1, 4);
        expect_ev(K_PC, 6'd1, 2'd0, 5);
        expect_ev(K_WE, 6'd2, 2'd1, 8);
        expect_ev(K_PC, 6'd2, 2'd0, 9);
        expect_ev(K_ALU, 6'd1, 2'd0, 11);
        expect_ev(K_WE, 6'd1, 2'd0, 12);
        expect_ev(K_PC, 6'd3, 2'd0, 13);
        expect_ev(K_WE, 6'd4, 2'd1, 16);
        expect_ev(K_PC, 6'd4, 2'd0, 17);
        expect_ev(K_PC, 6'd5, 2'd0, 20);
        start();
        idle(19);
        run = 1'b0;
        idle(6);
        check("beqz_fall_pc", {26'd0, pc_out}, 32'd5);
        check("sub_value", {16'd0, regs[1]}, 32'd4);
        drained("fall_drain");

        // LD r3,[20] with three wait cycles.
        clear_imem();
        imem[0]  = 16'h6614;
        mem_wait = 3;
        do_reset();
        for (int c = 4; c <= 7; c++) expect_ev(K_DRE, 6'd20, 2'd0, c);
        expect_ev(K_WE, 6'd3, 2'd2, 8);
        expect_ev(K_PC, 6'd1, 2'd0, 9);
        start();
        idle(8);
        run = 1'b0;
        idle(4);
        check("ld_data", {16'd0, regs[3]}, {16'd0, 16'hA014});
        drained("ld_drain");

        // JMP 63 then NOP at 63: PC wraps to 0.
        clear_imem();
        imem[0]  = 16'h803F;
        mem_wait = 0;
        do_reset();
        expect_ev(K_PC, 6'd63, 2'd0, 4);
        expect_ev(K_PC, 6'd0, 2'd0, 7);
        start();
        idle(6);
        run = 1'b0;
        idle(4);
        drained("wrap_drain");

        // Undefined opcode C: one illegal pulse, no strobes, PC+1.
        clear_imem();
        imem[0] = 16'hCABC;
        do_reset();
        expect_ev(K_ILL, 6'd0, 2'd0, 2);
        expect_ev(K_PC, 6'd1, 2'd0, 4);
        start();
        idle(3);
        run = 1'b0;
        idle(4);
        drained("ill_drain");

        // JMP 5; HLT at 5; run toggles; async reset exits HALT.
        clear_imem();
        imem[0] = 16'h8005;
        imem[5] = 16'hF000;
        do_reset();
        expect_ev(K_PC, 6'd5, 2'd0, 4);
        expect_ev(K_HLT, 6'd0, 2'd0, 6);
        start();
        idle(8);
        for (int i = 0; i < 10; i++) begin
            run = ~run;
            idle(1);
        end
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", {26'd0, pc_out}, 32'd5);
        drained("halt_drain");
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("halt_rst_pc", {26'd0, pc_out}, 32'd0);
        check("halt_rst_flag", {31'd0, halted}, 32'd0);

        // ST r2,[33] stalled; reset mid-MEM drops dmem_we at once.
        clear_imem();
        imem[0]  = 16'h7421;
        mem_wait = 10;
        do_reset();
        expect_ev(K_DWE, 6'd33, 2'd0, 4);
        start();
        idle(4);
        check("st_we_high", {31'd0, dmem_we}, 32'd1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("st_rst_we", {31'd0, dmem_we}, 32'd0);
        check("st_rst_pc", {26'd0, pc_out}, 32'd0);
        drained("st_drain");
        reset = 1'b1;
        run   = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
